player_sprite_renderer: RTL and testbench

//  Pixel-pipeline stage that drives the 20x20 astronaut sprite ROM and consumes its output.

---
 rtl/player_sprite_renderer.sv | 151 +++++++++++++++
 tb/tb_player_sprite_renderer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_sprite_renderer.sv
// Player sprite pixel stage: turns the scan position into a sprite ROM address and
// resolves the returned palette index into a transparency- and blink-aware pixel.
module player_sprite_renderer #(
    parameter int SPR_W        = 20,
    parameter int SPR_H        = 20,
    parameter int ADDR_W       = 19,
    parameter int IDX_W        = 3,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 60
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_start,
    input  logic [9:0]        player_x,
    input  logic [9:0]        player_y,
    input  logic              facing_left,
    input  logic              hit,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_data,
    output logic              sprite_valid,
    output logic              sprite_on,
    output logic [IDX_W-1:0]  sprite_idx
);

    // Frame-stable copies of the player state.
    logic [9:0] pos_x_q;
    logic [9:0] pos_y_q;
    logic       facing_q;

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!Reset_n) begin
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            facing_q <= 1'b0;
        end else if (frame_start) begin
            pos_x_q  <= player_x;
            pos_y_q  <= player_y;
            facing_q <= facing_left;
        end
    end

    // Bounds are formed in 11 bits so a sprite hanging off the right/bottom edge
    // clips instead of wrapping back to column/row 0.
    logic [10:0]       x_ext;
    logic [10:0]       y_ext;
    logic [10:0]       px_ext;
    logic [10:0]       py_ext;
    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic [10:0]       col;
    logic [10:0]       row;
    logic [10:0]       col_src;
    logic              in_box;
    logic [ADDR_W-1:0] lin_addr;

    assign x_ext  = {1'b0, DrawX};
    assign y_ext  = {1'b0, DrawY};
    assign px_ext = {1'b0, pos_x_q};
    assign py_ext = {1'b0, pos_y_q};
    assign x_end  = px_ext + 11'(SPR_W);
    assign y_end  = py_ext + 11'(SPR_H);
    assign col    = x_ext - px_ext;
    assign row    = y_ext - py_ext;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        col_src = col;
        if (facing_q) begin
            col_src = 11'(SPR_W - 1) - col;
        end
    end

    assign in_box = (x_ext >= px_ext) && (x_ext < x_end) &&
                    (y_ext >= py_ext) && (y_ext < y_end);

    // Constant multiply by the sprite width; the largest index fits ADDR_W.
    assign lin_addr = ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_src);

    // Stage 1: address issue. Stage 2: ROM access slot.
    logic v1;
    logic box1;
    logic v2;
    logic box2;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            v1       <= 1'b0;
            box1     <= 1'b0;
            v2       <= 1'b0;
            box2     <= 1'b0;
        end else begin
            rom_addr <= in_box ? lin_addr : '0;
            v1       <= pix_en;
            box1     <= in_box;
            v2       <= v1;
            box2     <= box1;
        end
    end

    // Hit blink: counts frames down from the load value; blank follows bit 2 of
    // the count but only changes on a frame boundary.
    logic [7:0] flash_cnt;
    logic [7:0] flash_next;
    logic       blank;

    always_comb begin
        flash_next = flash_cnt;
        if (hit) begin
            flash_next = 8'(FLASH_FRAMES);
        end else if (frame_start && (flash_cnt != 8'd0)) begin
            flash_next = flash_cnt - 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            flash_cnt <= '0;
            blank     <= 1'b0;
        end else begin
            flash_cnt <= flash_next;
            if (frame_start) begin
                blank <= (flash_next != 8'd0) && flash_next[2];
            end
        end
    end

    // Stage 3: transparency and blink resolution.
    logic opaque;

    assign opaque = box2 && (rom_data != IDX_W'(TRANSP_IDX)) && !blank;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sprite_valid <= 1'b0;
            sprite_on    <= 1'b0;
            sprite_idx   <= '0;
        end else begin
            sprite_valid <= v2;
            sprite_on    <= v2 && opaque;
            sprite_idx   <= (v2 && opaque) ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Bench for player_sprite_renderer: a pixel-level model built from the sprite geometry
// and blink rules is compared every cycle, plus hand-computed directed expectations.
module tb_player_sprite_renderer;

    localparam int SPR_W  = 20;
    localparam int SPR_H  = 20;
    localparam int NWORDS = SPR_W * SPR_H;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        frame_start = 1'b0;
    logic [9:0]  player_x = '0;
    logic [9:0]  player_y = '0;
    logic        facing_left = 1'b0;
    logic        hit = 1'b0;
    logic [18:0] rom_addr;
    logic [2:0]  rom_data = '0;
    logic        sprite_valid;
    logic        sprite_on;
    logic [2:0]  sprite_idx;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    player_sprite_renderer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .pix_en       (pix_en),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .frame_start  (frame_start),
        .player_x     (player_x),
        .player_y     (player_y),
        .facing_left  (facing_left),
        .hit          (hit),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sprite_valid (sprite_valid),
        .sprite_on    (sprite_on),
        .sprite_idx   (sprite_idx)
    );

    // Registered sprite ROM: data appears one clock after the address.
    logic [2:0] rom_mem [0:NWORDS-1];

    always @(posedge Clk) begin
        if (int'(rom_addr) < NWORDS) rom_data <= rom_mem[int'(rom_addr)];
        else                         rom_data <= '0;
    end

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Pixel-level model: geometry in plain integers, outputs delivered after two
    // further clock edges through a queue of pending pixels.
    typedef struct packed {
        logic       v;
        logic       box;
        logic [2:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   exp_addr = 0;
    int   pos_x_m = 0;
    int   pos_y_m = 0;
    bit   face_m = 0;
    int   cnt_m = 0;
    bit   blank_m = 0;
    bit   blank_prev = 0;
    bit   model_live = 0;

    always @(posedge Clk) begin
        int   x;
        int   y;
        int   c;
        bit   inb;
        exp_t e;
        blank_prev = blank_m;
        if (!Reset_n) begin
            exp_q.delete();
            repeat (3) exp_q.push_back('0);
            exp_addr = 0;
            pos_x_m = 0;
            pos_y_m = 0;
            face_m = 0;
            cnt_m = 0;
            blank_m = 0;
            model_live = 1;
        end else begin
            x = int'(DrawX);
            y = int'(DrawY);
            inb = (x >= pos_x_m) && (x < pos_x_m + SPR_W) &&
                  (y >= pos_y_m) && (y < pos_y_m + SPR_H);
            c = face_m ? (SPR_W - 1 - (x - pos_x_m)) : (x - pos_x_m);
            exp_addr = inb ? ((y - pos_y_m) * SPR_W + c) : 0;
            e.v = pix_en;
            e.box = inb;
            e.data = inb ? rom_mem[exp_addr] : 3'd0;
            exp_q.push_back(e);
            if (frame_start) begin
                pos_x_m = int'(player_x);
                pos_y_m = int'(player_y);
                face_m = facing_left;
            end
            if (hit) cnt_m = 60;
            else if (frame_start && cnt_m > 0) cnt_m = cnt_m - 1;
            if (frame_start) blank_m = (cnt_m > 0) && ((cnt_m & 4) != 0);
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        bit   on;
        if (model_live) begin
            check("model rom_addr", rom_addr, exp_addr);
            if (exp_q.size() == 3) begin
                e = exp_q.pop_front();
                on = e.v && e.box && (e.data != 3'd0) && !blank_prev;
                check("model sprite_valid", sprite_valid, int'(e.v));
                check("model sprite_on", sprite_on, int'(on));
                check("model sprite_idx", sprite_idx, on ? int'(e.data) : 0);
            end
        end
    end

    task automatic step(input logic pe, input int x, input int y,
                        input logic fs = 1'b0, input logic h = 1'b0);
        pix_en = pe;
        DrawX = 10'(x);
        DrawY = 10'(y);
        frame_start = fs;
        hit = h;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle2();
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
    endtask

    initial begin
        for (int a = 0; a < NWORDS; a++) rom_mem[a] = 3'((a * 3) % 8);
        rom_mem[45] = 3'd5;
        rom_mem[54] = 3'd0;

        @(negedge Clk);
        // Reset held with pixels offered: nothing comes out.
        for (int i = 0; i < 3; i++) step(1'b1, 105, 52);
        check("reset rom_addr", rom_addr, 0);
        check("reset sprite_valid", sprite_valid, 0);
        check("reset sprite_on", sprite_on, 0);
        check("reset sprite_idx", sprite_idx, 0);

        Reset_n = 1'b1;
        step(1'b1, 5, 3);
        check("post-reset pos (0,0) addr", rom_addr, 65);
        idle2();

        // Basic address and data path.
        player_x = 10'd100; player_y = 10'd50; facing_left = 1'b0;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 105, 52);
        check("addr 105,52", rom_addr, 45);
        idle2();
        check("basic valid", sprite_valid, 1);
        check("basic on", sprite_on, 1);
        check("basic idx", sprite_idx, 5);

        // Mirrored lookup landing on a transparent word.
        facing_left = 1'b1;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 105, 52);
        check("mirror addr", rom_addr, 54);
        idle2();
        check("transparent valid", sprite_valid, 1);
        check("transparent on", sprite_on, 0);
        check("transparent idx", sprite_idx, 0);

        // Sprite hanging off the bottom-right corner.
        player_x = 10'd630; player_y = 10'd470; facing_left = 1'b0;
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 639, 479);
        check("edge addr", rom_addr, 189);
        step(1'b1, 0, 479);
        check("wrap addr", rom_addr, 0);
        step(1'b0, 0, 0);
        check("edge on", sprite_on, 1);
        check("edge idx", sprite_idx, 7);
        step(1'b0, 0, 0);
        check("wrap valid", sprite_valid, 1);
        check("wrap on", sprite_on, 0);

        // Mid-frame position change is ignored until the next frame_start.
        player_x = 10'd200;
        step(1'b1, 639, 479);
        check("latched addr", rom_addr, 189);
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 639, 479);
        check("relatched outside", rom_addr, 0);
        step(1'b1, 205, 479);
        check("relatched addr", rom_addr, 185);
        idle2();

        // Streaming sweep around a sprite, both facings, gappy pix_en.
        player_x = 10'd300; player_y = 10'd200;
        for (int f = 0; f < 2; f++) begin
            facing_left = f[0];
            step(1'b0, 0, 0, 1'b1);
            for (int y = 198; y < 223; y += 3)
                for (int x = 297; x < 323; x++)
                    step(((x + y) % 5) != 0, x, y);
        end

        // Reset in the middle of a stream drops in-flight pixels.
        for (int x = 300; x < 305; x++) step(1'b1, x, 205);
        Reset_n = 1'b0;
        step(1'b1, 306, 205);
        Reset_n = 1'b1;
        for (int x = 0; x < 8; x++) step(1'b1, x, 5);
        idle2();

        // Blink after a hit coinciding with frame_start.
        player_x = 10'd100; player_y = 10'd50; facing_left = 1'b0;
        step(1'b0, 0, 0, 1'b1, 1'b1);
        check("model cnt after hit", cnt_m, 60);
        step(1'b1, 105, 52);
        idle2();
        check("flash blank valid", sprite_valid, 1);
        check("flash blank on", sprite_on, 0);
        for (int i = 1; i <= 60; i++) begin
            step(1'b0, 0, 0, 1'b1);
            step(1'b1, 105, 52);
            idle2();
            if (i == 1) check("flash cnt59 on", sprite_on, 1);
            if (i == 5) check("flash cnt55 on", sprite_on, 0);
            if (i == 60) begin
                check("flash done on", sprite_on, 1);
                check("flash done idx", sprite_idx, 5);
                check("model cnt done", cnt_m, 0);
            end
        end
        step(1'b0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, 0, 0, 1'b1);
        check("model cnt 10", cnt_m, 10);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        check("model cnt reload", cnt_m, 60);
        for (int i = 0; i < 16; i++) step(1'b0, 0, 0, 1'b1);
        step(1'b1, 105, 52);
        idle2();
        check("reload cnt44 on", sprite_on, 0);
        check("model cnt 44", cnt_m, 44);
        idle2();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
